// File: rtl/uart_tx_drain_if.sv
// FIFO read-port bundle between the buffered-UART fifo and its serial drain.
// The drain side (master) issues pops; the fifo side (slave) returns flags and registered data.
interface uart_tx_drain_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  fifo_empty;
    logic                  fifo_read_enable;
    logic [DATA_WIDTH-1:0] fifo_data_out;

    modport master (
        input  fifo_empty,
        output fifo_read_enable,
        input  fifo_data_out
    );

    modport slave (
        output fifo_empty,
        input  fifo_read_enable,
        output fifo_data_out
    );
endinterface

// File: rtl/uart_tx_drain.sv
// Pops one byte per frame from the fifo and shifts it out as 8N1/8N2, LSB first; start bit 2 cycles after the pop.
// Never pops while a frame is in flight, so the fifo absorbs producer bursts; fifo_empty is only looked at in IDLE.
module uart_tx_drain #(
    parameter int DATA_WIDTH     = 8,
    parameter int CLOCKS_PER_BIT = 868,
    parameter int STOP_BITS      = 1
) (
    input  logic            clock,
    input  logic            reset,
    uart_tx_drain_if.master fifo,
    output logic            tx,
    output logic            busy,
    output logic            frame_done
);
    localparam int BAUD_W = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
    localparam int IDX_W  = $clog2(DATA_WIDTH + 1);
    localparam int STOP_W = (STOP_BITS > 1) ? $clog2(STOP_BITS) : 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLOCKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_WIDTH - 1);
    localparam logic [STOP_W-1:0] STOP_LAST = STOP_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        START,
        DATA,
        STOP
    } state_t;

    state_t                state, state_d;
    logic [DATA_WIDTH-1:0] shift, shift_d;
    logic [BAUD_W-1:0]     baud_cnt, baud_d;
    logic [IDX_W-1:0]      bit_idx, bit_idx_d;
    logic [STOP_W-1:0]     stop_cnt, stop_d;
    logic                  tx_d;
    logic                  pop;
    logic                  baud_last;

    assign baud_last             = (baud_cnt == BAUD_LAST);
    assign fifo.fifo_read_enable = pop;
    assign busy                  = (state != IDLE) || pop;

    always_comb begin
        state_d    = state;
        shift_d    = shift;
        baud_d     = baud_cnt;
        bit_idx_d  = bit_idx;
        stop_d     = stop_cnt;
        tx_d       = tx;
        pop        = 1'b0;
        frame_done = 1'b0;

        case (state)
            IDLE: begin
                tx_d = 1'b1;
                if (!fifo.fifo_empty && !reset) begin
                    pop     = 1'b1;
                    state_d = FETCH;
                end
            end
            // Read data is registered in the fifo, so it lands here one cycle after the pop.
            FETCH: begin
                shift_d   = fifo.fifo_data_out;
                tx_d      = 1'b0;
                baud_d    = '0;
                bit_idx_d = '0;
                state_d   = START;
            end
            START: begin
                if (baud_last) begin
                    baud_d  = '0;
                    tx_d    = shift[0];
                    state_d = DATA;
                end else begin
                    baud_d = baud_cnt + 1'b1;
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_d    = '0;
                    bit_idx_d = bit_idx + 1'b1;
                    shift_d   = shift >> 1;
                    if (bit_idx == IDX_LAST) begin
                        tx_d    = 1'b1;
                        stop_d  = '0;
                        state_d = STOP;
                    end else begin
                        tx_d = shift_d[0];
                    end
                end else begin
                    baud_d = baud_cnt + 1'b1;
                end
            end
            STOP: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (stop_cnt == STOP_LAST) begin
                        frame_done = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        stop_d = stop_cnt + 1'b1;
                    end
                end else begin
                    baud_d = baud_cnt + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A reset mid-frame drops the popped byte; the fifo has already advanced past it.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            tx       <= 1'b1;
            shift    <= '0;
            baud_cnt <= '0;
            bit_idx  <= '0;
            stop_cnt <= '0;
        end else begin
            state    <= state_d;
            tx       <= tx_d;
            shift    <= shift_d;
            baud_cnt <= baud_d;
            bit_idx  <= bit_idx_d;
            stop_cnt <= stop_d;
        end
    end
endmodule

// File: tb/tb_uart_tx_drain.sv
// Bench for uart_tx_drain: queue-backed fifo with registered read data, a mid-bit sampling
// UART receiver and a byte scoreboard, plus directed cycle-exact frame checks.
module tb_uart_tx_drain;
    localparam int DW    = 8;
    localparam int CPB   = 4;
    localparam int SB    = 1;
    localparam int FRAME = (1 + DW + SB) * CPB;
    localparam int HMAX  = 40000;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic tx, busy, frame_done;

    uart_tx_drain_if #(.DATA_WIDTH(DW)) fifo_if ();

    uart_tx_drain #(
        .DATA_WIDTH    (DW),
        .CLOCKS_PER_BIT(CPB),
        .STOP_BITS     (SB)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .fifo      (fifo_if),
        .tx        (tx),
        .busy      (busy),
        .frame_done(frame_done)
    );

    always #5 clock = ~clock;

    int n_compared   = 0;
    int n_mismatched = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Fifo model: data is registered on the pop edge, empty follows the stored count.
    logic [DW-1:0] fq[$];
    logic          push_vld = 1'b0;
    logic [DW-1:0] push_dat = '0;
    logic [DW-1:0] rd_dat   = '0;
    int            fcount   = 0;
    int            cyc      = 0;

    assign fifo_if.fifo_empty    = (fcount == 0);
    assign fifo_if.fifo_data_out = rd_dat;

    always @(posedge clock) begin
        cyc++;
        if (fifo_if.fifo_read_enable && fq.size() > 0) rd_dat <= fq.pop_front();
        if (push_vld) fq.push_back(push_dat);
        fcount <= fq.size();
    end

    logic          tx_hist[HMAX];
    logic          busy_hist[HMAX];
    logic          done_hist[HMAX];
    int            pop_cyc[$];
    int            done_cyc[$];
    logic          prev_busy  = 1'b0;
    logic          prev_done  = 1'b0;
    logic          prev_reset = 1'b1;
    logic [DW-1:0] exp_q[$];
    int            rx_total = 0;
    logic          rx_on    = 1'b0;
    int            rx_t     = 0;
    logic [DW-1:0] rx_b     = '0;

    always @(negedge clock) begin
        int k;
        if (cyc < HMAX) begin
            tx_hist[cyc]   = tx;
            busy_hist[cyc] = busy;
            done_hist[cyc] = frame_done;
        end
        if (fifo_if.fifo_read_enable) pop_cyc.push_back(cyc);
        if (frame_done) done_cyc.push_back(cyc);
        // A pop is legal only from an idle line, after a finished frame, or right after reset.
        if (reset || fifo_if.fifo_empty || (prev_busy && !prev_done && !prev_reset))
            chk("pop_gate", fifo_if.fifo_read_enable, 0);
        prev_busy  = busy;
        prev_done  = frame_done;
        prev_reset = reset;

        if (reset) begin
            if (rx_on && exp_q.size() > 0) exp_q.delete(0);
            rx_on = 1'b0;
        end else if (!rx_on) begin
            if (tx == 1'b0) begin
                rx_on = 1'b1;
                rx_t  = 0;
            end
        end else begin
            rx_t++;
        end
        if (rx_on && (rx_t % CPB) == CPB / 2) begin
            k = rx_t / CPB;
            if (k == 0) begin
                chk("rx_start", tx, 0);
            end else if (k <= DW) begin
                rx_b[k-1] = tx;
            end else begin
                chk("rx_stop", tx, 1);
                if (exp_q.size() > 0) chk("rx_byte", rx_b, exp_q.pop_front());
                else chk("rx_unexpected", exp_q.size(), 1);
                rx_total++;
                rx_on = 1'b0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic push(input logic [DW-1:0] b);
        push_vld = 1'b1;
        push_dat = b;
        exp_q.push_back(b);
        tick(1);
        push_vld = 1'b0;
    endtask

    // Line shape for a frame popped at cycle p: start, DW data bits LSB first, stop, each CPB cycles.
    task automatic check_frame(input string tag, input int p, input logic [DW-1:0] b);
        logic e;
        int   k;
        if (p + FRAME + 3 >= HMAX) begin
            chk({tag, "_range"}, p, 0);
            return;
        end
        for (int c = p + 2; c < p + 2 + FRAME; c++) begin
            k = (c - p - 2) / CPB;
            if (k == 0) e = 1'b0;
            else if (k <= DW) e = b[k-1];
            else e = 1'b1;
            chk({tag, "_tx"}, tx_hist[c], e);
        end
        chk({tag, "_busy_pop"}, busy_hist[p], 1);
        chk({tag, "_busy_end"}, busy_hist[p+1+FRAME], 1);
        chk({tag, "_done"}, done_hist[p+1+FRAME], 1);
        chk({tag, "_done_early"}, done_hist[p+FRAME], 0);
    endtask

    initial begin
        int p, d, r, rel, base;

        tick(1);
        push(8'hA5);
        repeat (3) begin
            @(negedge clock);
            chk("rst_tx", tx, 1);
            chk("rst_busy", busy, 0);
            chk("rst_done", frame_done, 0);
            chk("rst_rd", fifo_if.fifo_read_enable, 0);
        end
        @(posedge clock);
        #1;
        pop_cyc.delete();
        done_cyc.delete();
        reset = 1'b0;
        rel   = cyc;
        tick(FRAME + 10);
        chk("s2_pops", pop_cyc.size(), 1);
        if (pop_cyc.size() > 0) begin
            p = pop_cyc[0];
            chk("s2_pop_after_reset", p, rel);
            check_frame("s2", p, 8'hA5);
            chk("s2_busy_idle", busy_hist[p+2+FRAME], 0);
        end

        pop_cyc.delete();
        done_cyc.delete();
        push(8'h00);
        push(8'hFF);
        tick(2 * FRAME + 20);
        chk("s3_pops", pop_cyc.size(), 2);
        chk("s3_dones", done_cyc.size(), 2);
        if (pop_cyc.size() == 2 && done_cyc.size() >= 1) begin
            d = done_cyc[0];
            chk("s3_gap_pop", pop_cyc[1], d + 1);
            chk("s3_gap_hi1", tx_hist[d+1], 1);
            chk("s3_gap_hi2", tx_hist[d+2], 1);
            check_frame("s3a", pop_cyc[0], 8'h00);
            check_frame("s3b", pop_cyc[1], 8'hFF);
        end

        pop_cyc.delete();
        done_cyc.delete();
        push(8'h3C);
        push(8'h81);
        for (int i = 0; i < 20 && pop_cyc.size() == 0; i++) tick(1);
        chk("s4_first_pop", pop_cyc.size(), 1);
        if (pop_cyc.size() > 0) begin
            p = pop_cyc[0];
            while (cyc < p + 2 + CPB * 4 + 1) tick(1);
            reset = 1'b1;
            tick(1);
            reset = 1'b0;
            r     = cyc;
            tick(FRAME + 10);
            chk("s4_line_high", tx_hist[r], 1);
            chk("s4_pops", pop_cyc.size(), 2);
            chk("s4_dones", done_cyc.size(), 1);
            if (pop_cyc.size() >= 2) begin
                chk("s4_repop", pop_cyc[1], r);
                check_frame("s4", pop_cyc[1], 8'h81);
            end
        end

        pop_cyc.delete();
        done_cyc.delete();
        push(8'h5A);
        tick(FRAME + 20);
        chk("s5_pops", pop_cyc.size(), 1);
        chk("s5_dones", done_cyc.size(), 1);
        if (pop_cyc.size() > 0) check_frame("s5", pop_cyc[0], 8'h5A);

        base = rx_total;
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 3) != 0) tick($urandom_range(1, 90));
            push(8'($urandom));
        end
        for (int i = 0; i < 20000 && (exp_q.size() > 0 || rx_on); i++) tick(1);
        chk("s6_drained", exp_q.size(), 0);
        chk("s6_count", rx_total - base, 200);
        chk("rx_total", rx_total, 205);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
